// File: rtl/if_fetch.sv
// Instruction-fetch front end: drives instruction-memory requests and presents pc/inst to IF/ID.
// Optional FETCH_PERF_CNT_EN adds consumed-instruction and stalled-cycle counters.
//
// state | meaning
// BOOT  | one idle cycle after reset release
// REQ   | request fetch_pc, hold until granted
// WAIT  | request granted, awaiting response
// HOLD  | response parked in skid, output stalled
// DROP  | redirected while a response is outstanding; discard it
module if_fetch #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic              rom_gnt_i,
    input  logic              rom_rvalid_i,
    input  logic [DATA_W-1:0] rom_rdata_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] inst_o,
    output logic              inst_valid_o
`ifdef FETCH_PERF_CNT_EN
   ,output logic [31:0]       perf_fetch_cnt_o,
    output logic [31:0]       perf_stall_cnt_o
`endif
);

    typedef enum logic [2:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_d;
    logic [ADDR_W-1:0] req_pc, req_pc_d;
    logic [ADDR_W-1:0] skid_pc, skid_pc_d;
    logic [DATA_W-1:0] skid_inst, skid_inst_d;
    logic [ADDR_W-1:0] pc_d;
    logic [DATA_W-1:0] inst_d;
    logic              valid_d;
    logic              consume;

    assign consume = inst_valid_o & ~stall_i;

    always_comb begin
        state_d     = state;
        fetch_pc_d  = fetch_pc;
        req_pc_d    = req_pc;
        skid_pc_d   = skid_pc;
        skid_inst_d = skid_inst;
        pc_d        = pc_o;
        inst_d      = inst_o;
        valid_d     = inst_valid_o & ~consume;
        rom_ce_o    = 1'b0;
        rom_addr_o  = fetch_pc;

        case (state)
            S_BOOT: state_d = S_REQ;
            S_REQ: begin
                // A redirect withdraws the request combinationally so it can never be granted.
                rom_ce_o = ~branch_flag_i;
                if (rom_gnt_i && !branch_flag_i) begin
                    req_pc_d   = fetch_pc;
                    fetch_pc_d = fetch_pc + ADDR_W'(4);
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rom_rvalid_i) begin
                    if (!inst_valid_o || consume) begin
                        pc_d    = req_pc;
                        inst_d  = rom_rdata_i;
                        valid_d = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        skid_pc_d   = req_pc;
                        skid_inst_d = rom_rdata_i;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (consume) begin
                    pc_d    = skid_pc;
                    inst_d  = skid_inst;
                    valid_d = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_DROP: if (rom_rvalid_i) state_d = S_REQ;
            default: state_d = S_BOOT;
        endcase

        if (branch_flag_i) begin
            fetch_pc_d = {branch_target_i[ADDR_W-1:2], 2'b00};
            if (state != S_DROP) begin
                valid_d     = 1'b0;
                skid_pc_d   = '0;
                skid_inst_d = '0;
                state_d     = (state == S_WAIT && !rom_rvalid_i) ? S_DROP : S_REQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_BOOT;
            fetch_pc     <= RESET_PC;
            req_pc       <= '0;
            skid_pc      <= '0;
            skid_inst    <= '0;
            pc_o         <= '0;
            inst_o       <= '0;
            inst_valid_o <= 1'b0;
        end else begin
            state        <= state_d;
            fetch_pc     <= fetch_pc_d;
            req_pc       <= req_pc_d;
            skid_pc      <= skid_pc_d;
            skid_inst    <= skid_inst_d;
            pc_o         <= pc_d;
            inst_o       <= inst_d;
            inst_valid_o <= valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // A word flushed by a redirect in the same cycle is not counted as fetched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt_o <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            if (consume && !branch_flag_i) perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
            if (inst_valid_o && stall_i)   perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: directed scenarios plus randomized traffic against a stream-level model.
// Counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_if_fetch;
    localparam logic [31:0] K = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, branch_flag_i;
    logic [31:0] branch_target_i;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic        rom_gnt_i, rom_rvalid_i;
    logic [31:0] rom_rdata_i;
    logic [31:0] pc_o, inst_o;
    logic        inst_valid_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt_o, perf_stall_cnt_o;
`endif

    if_fetch dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
        .branch_target_i(branch_target_i), .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o),
        .rom_gnt_i(rom_gnt_i), .rom_rvalid_i(rom_rvalid_i), .rom_rdata_i(rom_rdata_i),
        .pc_o(pc_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o)
`ifdef FETCH_PERF_CNT_EN
       ,.perf_fetch_cnt_o(perf_fetch_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // memory model: one pending response, delivered dly cycles after grant
    bit          pend;
    logic [31:0] pend_addr;
    int          pend_wait;
    bit          overlap;

    logic        obs_ce, obs_gnt, obs_rvalid, obs_valid;
    logic [31:0] obs_addr, obs_pc, obs_inst;

    task automatic tick(input logic st, input logic br, input logic [31:0] tgt,
                        input logic gnt_ok, input int dly);
        stall_i = st;
        branch_flag_i = br;
        branch_target_i = tgt;
        #1;
        rom_gnt_i = rom_ce_o & gnt_ok;
        if (pend && pend_wait == 0) begin
            rom_rvalid_i = 1'b1;
            rom_rdata_i  = pend_addr ^ K;
        end else begin
            rom_rvalid_i = 1'b0;
            rom_rdata_i  = $urandom;
        end
        #1;
        obs_ce = rom_ce_o;   obs_addr = rom_addr_o; obs_gnt = rom_gnt_i;
        obs_rvalid = rom_rvalid_i;
        obs_pc = pc_o;       obs_inst = inst_o;     obs_valid = inst_valid_o;
        @(posedge clk);
        if (obs_rvalid) pend = 1'b0;
        else if (pend) pend_wait = pend_wait - 1;
        if (obs_gnt) begin
            if (pend) overlap = 1'b1;
            pend = 1'b1;
            pend_addr = obs_addr;
            pend_wait = dly - 1;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        stall_i = 1'b0; branch_flag_i = 1'b0; branch_target_i = '0;
        rom_gnt_i = 1'b0; rom_rvalid_i = 1'b0; rom_rdata_i = '0;
        pend = 1'b0; overlap = 1'b0; pend_wait = 0; pend_addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        stall_i = 1'b0; branch_flag_i = 1'b0; branch_target_i = '0;
        rom_gnt_i = 1'b0; rom_rvalid_i = 1'b0; rom_rdata_i = '0;
        pend = 1'b0; overlap = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({rom_ce_o, rom_addr_o, pc_o, inst_o, inst_valid_o} !== 98'd0) begin
            bad++;
            $display("FAIL reset_values: ce=%b addr=%h pc=%h inst=%h valid=%b, expected all zero",
                     rom_ce_o, rom_addr_o, pc_o, inst_o, inst_valid_o);
        end
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            logic        ev;
            logic [31:0] ep;
            tick(1'b0, 1'b0, '0, 1'b1, 1);
            ev = (k >= 3) && (k % 2 == 1);
            ep = 32'((k - 3) * 2);
            total++;
            if (obs_valid !== ev || (ev && (obs_pc !== ep || obs_inst !== (ep ^ K)))) begin
                bad++;
                $display("FAIL stream_k%0d: valid=%b pc=%h inst=%h, expected valid=%b pc=%h",
                         k, obs_valid, obs_pc, obs_inst, ev, ep);
            end
        end
    endtask

    task automatic test_stall();
        apply_reset();
        for (int k = 0; k < 16; k++) begin
            logic st;
            st = (k >= 7 && k <= 11);
            tick(st, 1'b0, '0, 1'b1, 1);
            if (k >= 7 && k <= 12) begin
                total++;
                if (obs_valid !== 1'b1 || obs_pc !== 32'd8 || obs_inst !== (32'd8 ^ K)) begin
                    bad++;
                    $display("FAIL stall_freeze_k%0d: valid=%b pc=%h inst=%h, expected pc 8 held",
                             k, obs_valid, obs_pc, obs_inst);
                end
            end
            if (k >= 9 && k <= 12) begin
                total++;
                if (obs_ce !== 1'b0) begin
                    bad++;
                    $display("FAIL hold_no_req_k%0d: ce=%b expected 0", k, obs_ce);
                end
            end
            if (k == 13) begin
                total++;
                if (obs_valid !== 1'b1 || obs_pc !== 32'd12 || obs_inst !== (32'd12 ^ K)
                    || obs_ce !== 1'b1 || obs_addr !== 32'd16) begin
                    bad++;
                    $display("FAIL skid_release: valid=%b pc=%h ce=%b addr=%h, expected pc 0xc, req 0x10",
                             obs_valid, obs_pc, obs_ce, obs_addr);
                end
            end
            if (k == 15) begin
                total++;
                if (obs_valid !== 1'b1 || obs_pc !== 32'd16) begin
                    bad++;
                    $display("FAIL resume_16: valid=%b pc=%h expected pc 0x10", obs_valid, obs_pc);
                end
            end
        end
    endtask

    task automatic test_branch_wait();
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, (k == 2), 32'h0000_0103, 1'b1, (k == 1) ? 3 : 1);
            if (k >= 3 && k <= 4) begin
                total++;
                if (obs_ce !== 1'b0 || obs_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL drop_idle_k%0d: ce=%b valid=%b expected 0/0", k, obs_ce, obs_valid);
                end
            end
            if (k == 5) begin
                total++;
                if (obs_ce !== 1'b1 || obs_addr !== 32'h100 || obs_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL redirect_req: ce=%b addr=%h valid=%b expected 1/0x100/0",
                             obs_ce, obs_addr, obs_valid);
                end
            end
            if (k == 7) begin
                total++;
                if (obs_valid !== 1'b1 || obs_pc !== 32'h100 || obs_inst !== (32'h100 ^ K)) begin
                    bad++;
                    $display("FAIL redirect_inst: valid=%b pc=%h inst=%h expected pc 0x100",
                             obs_valid, obs_pc, obs_inst);
                end
            end
        end
    endtask

    task automatic test_branch_rvalid_stall();
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            tick(k == 3 || k == 4, k == 4, 32'h0000_0200, 1'b1, 1);
            if (k == 4) begin
                total++;
                if (obs_rvalid !== 1'b1 || obs_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL setup_collision: rvalid=%b valid=%b expected 1/1", obs_rvalid, obs_valid);
                end
            end
            if (k == 5) begin
                total++;
                if (obs_valid !== 1'b0 || obs_ce !== 1'b1 || obs_addr !== 32'h200) begin
                    bad++;
                    $display("FAIL collision_flush: valid=%b ce=%b addr=%h expected 0/1/0x200",
                             obs_valid, obs_ce, obs_addr);
                end
            end
            if (k == 7) begin
                total++;
                if (obs_valid !== 1'b1 || obs_pc !== 32'h200) begin
                    bad++;
                    $display("FAIL collision_next: valid=%b pc=%h expected pc 0x200", obs_valid, obs_pc);
                end
            end
        end
    endtask

    task automatic test_gnt_hold_wrap();
        apply_reset();
        for (int k = 0; k < 11; k++) begin
            tick(1'b0, k == 1, 32'hFFFF_FFFF, (k >= 6), 1);
            if (k == 1) begin
                total++;
                if (obs_ce !== 1'b0) begin
                    bad++;
                    $display("FAIL withdraw: ce=%b expected 0 during redirect", obs_ce);
                end
            end
            if (k >= 2 && k <= 6) begin
                total++;
                if (obs_ce !== 1'b1 || obs_addr !== 32'hFFFF_FFFC) begin
                    bad++;
                    $display("FAIL gnt_wait_k%0d: ce=%b addr=%h expected 1/fffffffc", k, obs_ce, obs_addr);
                end
            end
            if (k == 8) begin
                total++;
                if (obs_valid !== 1'b1 || obs_pc !== 32'hFFFF_FFFC || obs_addr !== 32'd0) begin
                    bad++;
                    $display("FAIL wrap_top: valid=%b pc=%h addr=%h expected fffffffc/next req 0",
                             obs_valid, obs_pc, obs_addr);
                end
            end
            if (k == 10) begin
                total++;
                if (obs_valid !== 1'b1 || obs_pc !== 32'd0 || obs_inst !== K) begin
                    bad++;
                    $display("FAIL wrap_zero: valid=%b pc=%h inst=%h expected pc 0", obs_valid, obs_pc, obs_inst);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int k = 0; k < 5; k++) tick(k >= 3, 1'b0, '0, 1'b1, (k == 3) ? 3 : 1);
        stall_i = 1'b1;
        #1;
        total++;
        if (inst_valid_o !== 1'b1 || inst_o !== K) begin
            bad++;
            $display("FAIL pre_reset: valid=%b inst=%h expected 1/%h", inst_valid_o, inst_o, K);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({rom_ce_o, rom_addr_o, pc_o, inst_o, inst_valid_o} !== 98'd0) begin
            bad++;
            $display("FAIL async_reset: ce=%b addr=%h pc=%h inst=%h valid=%b expected all zero",
                     rom_ce_o, rom_addr_o, pc_o, inst_o, inst_valid_o);
        end
        pend = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick(1'b0, 1'b0, '0, 1'b0, 1);
            total++;
            if (obs_ce !== (k == 1) || obs_addr !== 32'd0) begin
                bad++;
                $display("FAIL post_reset_k%0d: ce=%b addr=%h expected ce=%0d addr 0", k, obs_ce, obs_addr, k);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, p_pc, p_inst, p_addr;
        logic        p_valid, p_st, p_br, p_ce, p_gnt;
        int          nfetch, nstall;
        apply_reset();
        tick(1'b0, 1'b0, '0, 1'b0, 1);
        exp_pc = 32'd0; nfetch = 0; nstall = 0;
        p_valid = 0; p_st = 0; p_br = 0; p_ce = 0; p_gnt = 0; p_pc = 0; p_inst = 0; p_addr = 0;
        for (int i = 0; i < 3000; i++) begin
            logic        st, br, g;
            logic [31:0] tgt;
            st  = ($urandom_range(0, 99) < 30);
            br  = ($urandom_range(0, 99) < 5);
            g   = ($urandom_range(0, 99) < 60);
            tgt = $urandom;
            tick(st, br, tgt, g, $urandom_range(1, 3));
            if (p_br) begin
                total++;
                if (obs_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL rnd_after_branch@%0d: valid=%b expected 0", i, obs_valid);
                end
            end else if (p_valid && p_st) begin
                total++;
                if (obs_valid !== 1'b1 || obs_pc !== p_pc || obs_inst !== p_inst) begin
                    bad++;
                    $display("FAIL rnd_stall_hold@%0d: valid=%b pc=%h inst=%h expected pc=%h inst=%h",
                             i, obs_valid, obs_pc, obs_inst, p_pc, p_inst);
                end
            end
            if (p_ce && !p_gnt && !p_br && !br) begin
                total++;
                if (obs_ce !== 1'b1 || obs_addr !== p_addr) begin
                    bad++;
                    $display("FAIL rnd_req_stable@%0d: ce=%b addr=%h expected 1/%h", i, obs_ce, obs_addr, p_addr);
                end
            end
            if (obs_ce) begin
                total++;
                if (obs_addr[1:0] !== 2'b00) begin
                    bad++;
                    $display("FAIL rnd_align@%0d: addr=%h expected low bits 0", i, obs_addr);
                end
            end
            if (obs_valid && !st && !br) begin
                total++;
                if (obs_pc !== exp_pc || obs_inst !== (exp_pc ^ K)) begin
                    bad++;
                    $display("FAIL rnd_stream@%0d: pc=%h inst=%h expected pc=%h inst=%h",
                             i, obs_pc, obs_inst, exp_pc, exp_pc ^ K);
                end
                exp_pc = exp_pc + 32'd4;
                nfetch++;
            end
            if (obs_valid && st) nstall++;
            if (br) exp_pc = {tgt[31:2], 2'b00};
            p_valid = obs_valid; p_st = st; p_br = br; p_ce = obs_ce; p_gnt = obs_gnt;
            p_pc = obs_pc; p_inst = obs_inst; p_addr = obs_addr;
        end
        total++;
        if (overlap !== 1'b0) begin
            bad++;
            $display("FAIL rnd_single_outstanding: overlap=%b expected 0", overlap);
        end
        total++;
        if (nfetch < 200) begin
            bad++;
            $display("FAIL rnd_progress: fetched=%0d expected at least 200", nfetch);
        end
`ifdef FETCH_PERF_CNT_EN
        total++;
        if (perf_fetch_cnt_o !== 32'(nfetch) || perf_stall_cnt_o !== 32'(nstall)) begin
            bad++;
            $display("FAIL perf_counters: fetch=%0d stall=%0d expected %0d/%0d",
                     perf_fetch_cnt_o, perf_stall_cnt_o, nfetch, nstall);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stall();
        test_branch_wait();
        test_branch_rvalid_stall();
        test_gnt_hold_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
